// File: rtl/sram_access_sequencer.sv
// Precharge / word-line access sequencer for a custom SRAM macro, one access in flight.
// Optional access statistics are built when SRAM_SEQ_STATS_EN is defined.
module sram_access_sequencer #(
  parameter int PRE_CYC = 2,
  parameter int RD_CYC  = 2,
  parameter int WR_CYC  = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [9:0]  req_word,
  input  logic [1:0]  req_byte,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic [9:0]  sram_word_sel,
  output logic [1:0]  sram_byte_sel,
  output logic [7:0]  sram_din,
  input  logic [7:0]  sram_dout,
  output logic        sram_pre_b,
  output logic        sram_wl_en,
  output logic        sram_we,
  output logic        sram_re,
`ifdef SRAM_SEQ_STATS_EN
  output logic [15:0] stat_rd_cnt,
  output logic [15:0] stat_wr_cnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PRE, ACC, DONE} state_t;

  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD  = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_CYC - 1);

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             we_q;
  logic [7:0]       wdata_q;
  logic             accept;

  // Combinational from rsp_ready so a DONE cycle can accept back-to-back.
  assign req_ready = (state_q == IDLE) | ((state_q == DONE) & rsp_ready);
  assign accept    = req_valid & req_ready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_nx = PRE;
          cnt_nx   = PRE_LD;
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          state_nx = ACC;
          cnt_nx   = we_q ? WR_LD : RD_LD;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      ACC: begin
        if (cnt_q == '0) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          if (req_valid) begin
            state_nx = PRE;
            cnt_nx   = PRE_LD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Request capture: address and data hold until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      wdata_q       <= 8'h00;
      sram_word_sel <= 10'h000;
      sram_byte_sel <= 2'b00;
    end else if (accept) begin
      we_q          <= req_we;
      wdata_q       <= req_wdata;
      sram_word_sel <= req_word;
      sram_byte_sel <= req_byte;
    end
  end

  // Macro controls decode the next state so they are glitch-free flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_pre_b <= 1'b1;
      sram_wl_en <= 1'b0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
      sram_din   <= 8'h00;
      rsp_valid  <= 1'b0;
    end else begin
      sram_pre_b <= (state_nx != PRE);
      sram_wl_en <= (state_nx == ACC);
      sram_we    <= (state_nx == ACC) & we_q;
      sram_re    <= (state_nx == ACC) & ~we_q;
      sram_din   <= ((state_nx == ACC) & we_q) ? wdata_q : 8'h00;
      rsp_valid  <= (state_nx == DONE);
    end
  end

  // Read data is sampled on the final read-enable cycle and held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 8'h00;
    end else if ((state_q == ACC) && (cnt_q == '0) && !we_q) begin
      rsp_rdata <= sram_dout;
    end
  end

`ifdef SRAM_SEQ_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt <= 16'h0000;
      stat_wr_cnt <= 16'h0000;
    end else if (accept) begin
      if (req_we) stat_wr_cnt <= sat_inc(stat_wr_cnt);
      else        stat_rd_cnt <= sat_inc(stat_rd_cnt);
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule
